// File: rtl/parpadeo_pkg.sv
// Shared definitions for the LED blink protocol: state encoding, measurement width,
// default timing and the tolerance helper used by the receive side.
package parpadeo_pkg;

  localparam int W_MS        = 16;
  localparam int CICLOS_MS   = 50_000;
  localparam int PERIODO_NOM = 1000;
  localparam int ANCHO_NOM   = 200;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAJO   = 2'd2
  } estado_t;

  // 17-bit signed difference so a short reading never wraps into the tolerance band
  function automatic logic dentro_tol(input logic [W_MS-1:0] medida,
                                      input int nominal,
                                      input int tol);
    logic signed [W_MS:0] dif;
    logic signed [W_MS:0] nom;
    logic signed [W_MS:0] lim;
    nom = (W_MS+1)'(nominal);
    lim = (W_MS+1)'(tol);
    dif = $signed({1'b0, medida}) - nom;
    if (dif < 0) dif = -dif;
    return (dif <= lim);
  endfunction

endpackage

// File: rtl/detector_parpadeo_tick_ms.sv
// Millisecond prescaler: one-cycle Tick every CICLOS_MS clocks, realigned to zero
// whenever Reinicio is asserted.
module tick_ms
  import parpadeo_pkg::*;
#(
  parameter int CICLOS_MS = parpadeo_pkg::CICLOS_MS
) (
  input  logic Reloj,
  input  logic Reset,
  input  logic Reinicio,
  output logic Tick
);

  localparam int W = (CICLOS_MS > 1) ? $clog2(CICLOS_MS) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge Reloj) begin
    if (Reset || Reinicio)
      cnt <= '0;
    else if (cnt == W'(CICLOS_MS - 1))
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign Tick = (cnt == W'(CICLOS_MS - 1));

endmodule

// File: rtl/detector_parpadeo.sv
// Blink receiver: measures rising-to-rising period and high time in ms and flags
// whether the last measurement matches the nominal pattern.
//   state  | meaning
//   ESPERA | idle or signal lost, waiting for a first rising edge
//   ALTO   | input high, period and high-time counters running
//   BAJO   | input low, period counter running, high time latched
module detector_parpadeo
  import parpadeo_pkg::*;
#(
  parameter int CICLOS_MS   = parpadeo_pkg::CICLOS_MS,
  parameter int PERIODO_NOM = parpadeo_pkg::PERIODO_NOM,
  parameter int ANCHO_NOM   = parpadeo_pkg::ANCHO_NOM,
  parameter int TOL_MS      = 5,
  parameter int TIMEOUT_MS  = 3000
) (
  input  logic            Reloj,
  input  logic            Reset,
  input  logic            Entrada,
  output logic [W_MS-1:0] Periodo_ms,
  output logic [W_MS-1:0] Ancho_ms,
  output logic            Medida_valida,
  output logic            Patron_ok,
  output logic            Sin_senal
);

  logic            s1, s2, s3;
  logic            sube, baja, tick;
  estado_t         estado;
  logic [W_MS-1:0] cnt_per, cnt_alto, ancho_tmp;
  logic [W_MS-1:0] cnt_per_inc, cnt_alto_inc;
  logic            timeout, patron_nuevo;

  // Chain resets high so an input already high out of reset is not seen as a rising edge
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= Entrada;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sube = s2 & ~s3;
  assign baja = ~s2 & s3;

  tick_ms #(.CICLOS_MS(CICLOS_MS)) u_tick (
    .Reloj   (Reloj),
    .Reset   (Reset),
    .Reinicio(sube),
    .Tick    (tick)
  );

  // A tick landing on the closing edge still belongs to the measurement (floor of elapsed ms)
  assign cnt_per_inc  = (tick && (cnt_per  != '1)) ? cnt_per  + W_MS'(1) : cnt_per;
  assign cnt_alto_inc = (tick && (cnt_alto != '1)) ? cnt_alto + W_MS'(1) : cnt_alto;
  assign timeout      = (cnt_per_inc >= W_MS'(TIMEOUT_MS));
  assign patron_nuevo = dentro_tol(cnt_per_inc, PERIODO_NOM, TOL_MS) &&
                        dentro_tol(ancho_tmp, ANCHO_NOM, TOL_MS);

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado        <= ESPERA;
      cnt_per       <= '0;
      cnt_alto      <= '0;
      ancho_tmp     <= '0;
      Periodo_ms    <= '0;
      Ancho_ms      <= '0;
      Medida_valida <= 1'b0;
      Patron_ok     <= 1'b0;
      Sin_senal     <= 1'b0;
    end else begin
      Medida_valida <= 1'b0;
      case (estado)
        ESPERA: begin
          if (sube) begin
            estado    <= ALTO;
            cnt_per   <= '0;
            cnt_alto  <= '0;
            Sin_senal <= 1'b0;
          end
        end
        ALTO: begin
          cnt_per  <= cnt_per_inc;
          cnt_alto <= cnt_alto_inc;
          if (baja) begin
            estado    <= BAJO;
            ancho_tmp <= cnt_alto_inc;
          end else if (timeout) begin
            estado    <= ESPERA;
            Sin_senal <= 1'b1;
            Patron_ok <= 1'b0;
          end
        end
        BAJO: begin
          cnt_per <= cnt_per_inc;
          if (sube) begin
            estado        <= ALTO;
            Periodo_ms    <= cnt_per_inc;
            Ancho_ms      <= ancho_tmp;
            Medida_valida <= 1'b1;
            Patron_ok     <= patron_nuevo;
            cnt_per       <= '0;
            cnt_alto      <= '0;
          end else if (timeout) begin
            estado    <= ESPERA;
            Sin_senal <= 1'b1;
            Patron_ok <= 1'b0;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule
